ika9958_st_prog: RTL and testbench

- Parametrised, register-programmable successor to the fixed-PLA screen timing generator.
- Horizontal and vertical counters count against programmable totals instead of hard-coded PLA decodes.
- Generates HSYNC, VSYNC, CSYNC, BLANK, field, display-enable, signed-adjusted H/V positions and a line-match tick.
- Sits between the register file and the pattern/sprite/video-output stages; one instance per display pipe.

---
 rtl/ika9958_st_prog_pkg.sv | 31 +++
 rtl/ika9958_st_prog_if.sv | 32 +++
 rtl/ika9958_st_prog_srl.sv | 34 +++
 rtl/ika9958_st_prog.sv | 176 +++++++++++++++++
 tb/tb_ika9958_st_prog.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ika9958_st_prog_pkg.sv
// ika9958_st_pkg: shared types and defaults for the programmable screen
// timing generator (ika9958_st_prog).
//   st_hcnt_t / st_vcnt_t : default-width horizontal / vertical counts
//   st_field_e            : interlace field (primary / secondary)
//   ST_HTOTAL_NTSC / ST_VTOTAL_NTSC : NTSC totals (342 clocks x 262 lines)
package ika9958_st_pkg;

  localparam int unsigned ST_HW_DEF   = 9;
  localparam int unsigned ST_VW_DEF   = 9;
  localparam int unsigned ST_ADJW_DEF = 4;

  typedef logic [ST_HW_DEF-1:0] st_hcnt_t;
  typedef logic [ST_VW_DEF-1:0] st_vcnt_t;

  typedef enum logic {
    FIELD_PRI = 1'b0,
    FIELD_SEC = 1'b1
  } st_field_e;

  localparam st_hcnt_t ST_HTOTAL_NTSC = 9'd341;
  localparam st_vcnt_t ST_VTOTAL_NTSC = 9'd261;

  // Field after the last line of a field: alternate when interlaced,
  // otherwise always fall back to the primary field.
  function automatic st_field_e st_field_next(input logic il, input st_field_e f);
    if (!il)              return FIELD_PRI;
    if (f == FIELD_PRI)   return FIELD_SEC;
    return FIELD_PRI;
  endfunction

endpackage

// File: rtl/ika9958_st_prog_if.sv
// ika9958_st_prog_if: register-file programming bus for ika9958_st_prog.
//   master : register file (drives totals, sync/blank windows, IL, adjust,
//            line compare)
//   slave  : timing generator (reads them)
interface ika9958_st_prog_if
  import ika9958_st_pkg::*;
#(
  parameter int HW   = ST_HW_DEF,
  parameter int VW   = ST_VW_DEF,
  parameter int ADJW = ST_ADJW_DEF
);
  logic [HW-1:0]   i_HTOTAL;
  logic [HW-1:0]   i_HS_BEG, i_HS_END;
  logic [HW-1:0]   i_HB_BEG, i_HB_END;
  logic [VW-1:0]   i_VTOTAL;
  logic [VW-1:0]   i_VS_BEG, i_VS_END;
  logic [VW-1:0]   i_VB_BEG, i_VB_END;
  logic            i_IL;
  logic [ADJW-1:0] i_HADJ, i_VADJ;
  logic [VW-1:0]   i_LINE_CMP;

  modport master (
    output i_HTOTAL, i_HS_BEG, i_HS_END, i_HB_BEG, i_HB_END,
           i_VTOTAL, i_VS_BEG, i_VS_END, i_VB_BEG, i_VB_END,
           i_IL, i_HADJ, i_VADJ, i_LINE_CMP
  );
  modport slave (
    input  i_HTOTAL, i_HS_BEG, i_HS_END, i_HB_BEG, i_HB_END,
           i_VTOTAL, i_VS_BEG, i_VS_END, i_VB_BEG, i_VB_END,
           i_IL, i_HADJ, i_VADJ, i_LINE_CMP
  );
endinterface

// File: rtl/ika9958_st_prog_srl.sv
// ika9958_st_prog_srl: one-bit set/reset flag for a sync or blank window.
//   i_clk/i_rst : clock, synchronous active-high reset (to RST_VAL)
//   i_cen       : clock enable
//   i_upd       : flag may change only when high
//   i_set/i_clr : set / clear request; set wins when both are high
//   o_nx        : value the flag takes on the next enabled edge
module ika9958_st_prog_srl
  import ika9958_st_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cen,
  input  logic i_upd,
  input  logic i_set,
  input  logic i_clr,
  output logic o_nx
);
  logic r_q;

  always_comb begin
    o_nx = r_q;
    if (i_upd) begin
      if (i_set)      o_nx = 1'b1;
      else if (i_clr) o_nx = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_q <= RST_VAL;
    else if (i_cen) r_q <= o_nx;
  end
endmodule

// File: rtl/ika9958_st_prog.sv
// ika9958_st_prog: register-programmable screen timing generator.
//   i_phiA, i_RST, i_CEN : clock, sync active-high reset, pixel enable
//   i_REG                : programming bus (ika9958_st_prog_if.slave)
//   i_HRST_n, i_VRST_n   : genlock resets, used only with
//                          IKA9958_ST_PROG_GENLOCK_EN defined
//   o_HCNT/o_VCNT, o_HPOS/o_VPOS, syncs, blank, DE, field, line tick:
//   all registered one CEN after the counter state that produces them.
module ika9958_st_prog
  import ika9958_st_pkg::*;
#(
  parameter int HW   = ST_HW_DEF,
  parameter int VW   = ST_VW_DEF,
  parameter int ADJW = ST_ADJW_DEF
) (
  input  logic              i_phiA,
  input  logic              i_RST,
  input  logic              i_CEN,
  ika9958_st_prog_if.slave  i_REG,
  input  logic              i_HRST_n,
  input  logic              i_VRST_n,
  output logic [HW-1:0]     o_HCNT,
  output logic [VW-1:0]     o_VCNT,
  output logic [HW-1:0]     o_HPOS,
  output logic [VW-1:0]     o_VPOS,
  output logic              o_HSYNC_n,
  output logic              o_VSYNC_n,
  output logic              o_CSYNC_n,
  output logic              o_BLANK_n,
  output logic              o_DE,
  output logic              o_FIELD,
  output logic              o_LINE_TICK
);
  logic [HW-1:0] r_hcnt, w_hcnt_nx;
  logic [VW-1:0] r_vcnt, w_vcnt_nx;
  st_field_e     r_field, w_field_nx;
  logic [VW-1:0] w_vlast;
  logic          w_hwrap, w_vci, w_vwrap;
  logic [HW:0]   w_htot_p1;
  logic [HW-1:0] w_hhalf;
  logic          w_vupd;
  logic          w_hrst, w_vrst;
  logic [HW-1:0] w_hpos;
  logic [VW-1:0] w_vpos;
  logic          w_hs_nx, w_hb_nx, w_vs_nx, w_vb_nx;

  logic [HW-1:0] r_hcnt_o, r_hpos;
  logic [VW-1:0] r_vcnt_o, r_vpos;
  st_field_e     r_field_o;
  logic          r_hsync_n, r_vsync_n, r_csync_n, r_blank_n, r_de, r_tick;

`ifdef IKA9958_ST_PROG_GENLOCK_EN
  logic [2:0] r_hrst_sh, r_vrst_sh;

  always_ff @(posedge i_phiA) begin
    if (i_RST) begin
      r_hrst_sh <= '1;
      r_vrst_sh <= '1;
    end else if (i_CEN) begin
      r_hrst_sh <= {r_hrst_sh[1:0], i_HRST_n};
      r_vrst_sh <= {r_vrst_sh[1:0], i_VRST_n};
    end
  end

  assign w_hrst = r_hrst_sh[2] & ~r_hrst_sh[1];
  assign w_vrst = r_vrst_sh[2] & ~r_vrst_sh[1];
`else
  logic w_unused_genlock;
  assign w_unused_genlock = i_HRST_n ^ i_VRST_n;
  assign w_hrst = 1'b0;
  assign w_vrst = 1'b0;
`endif

  // >= so a downward reprogram of HTOTAL/VTOTAL recovers on the next wrap.
  assign w_hwrap = (r_hcnt >= i_REG.i_HTOTAL);
  assign w_vci   = (r_hcnt == i_REG.i_HTOTAL);
  assign w_vlast = (i_REG.i_IL && r_field == FIELD_SEC) ? i_REG.i_VTOTAL - VW'(1)
                                                        : i_REG.i_VTOTAL;
  assign w_vwrap = w_vci && (r_vcnt >= w_vlast);

  always_comb begin
    w_hcnt_nx  = w_hwrap ? '0 : r_hcnt + HW'(1);
    w_vcnt_nx  = r_vcnt;
    w_field_nx = r_field;
    if (w_vci) begin
      if (w_vwrap) begin
        w_vcnt_nx  = '0;
        w_field_nx = st_field_next(i_REG.i_IL, r_field);
      end else begin
        w_vcnt_nx  = r_vcnt + VW'(1);
      end
    end
    if (w_hrst) w_hcnt_nx = '0;
    if (w_vrst) begin
      w_hcnt_nx  = '0;
      w_vcnt_nx  = '0;
      w_field_nx = FIELD_PRI;
    end
  end

  always_ff @(posedge i_phiA) begin
    if (i_RST) begin
      r_hcnt  <= '0;
      r_vcnt  <= '0;
      r_field <= FIELD_PRI;
    end else if (i_CEN) begin
      r_hcnt  <= w_hcnt_nx;
      r_vcnt  <= w_vcnt_nx;
      r_field <= w_field_nx;
    end
  end

  // V flags sample once per line; the secondary interlaced field shifts
  // that sample point by half a line.
  assign w_htot_p1 = {1'b0, i_REG.i_HTOTAL} + (HW+1)'(1);
  assign w_hhalf   = w_htot_p1[HW:1];
  assign w_vupd    = (i_REG.i_IL && r_field == FIELD_SEC) ? (r_hcnt == w_hhalf)
                                                          : (r_hcnt == i_REG.i_HS_BEG);

  ika9958_st_prog_srl #(.RST_VAL(1'b0)) u_hs (
    .i_clk(i_phiA), .i_rst(i_RST), .i_cen(i_CEN), .i_upd(1'b1),
    .i_set(r_hcnt == i_REG.i_HS_BEG), .i_clr(r_hcnt == i_REG.i_HS_END), .o_nx(w_hs_nx));
  ika9958_st_prog_srl #(.RST_VAL(1'b1)) u_hb (
    .i_clk(i_phiA), .i_rst(i_RST), .i_cen(i_CEN), .i_upd(1'b1),
    .i_set(r_hcnt == i_REG.i_HB_BEG), .i_clr(r_hcnt == i_REG.i_HB_END), .o_nx(w_hb_nx));
  ika9958_st_prog_srl #(.RST_VAL(1'b0)) u_vs (
    .i_clk(i_phiA), .i_rst(i_RST), .i_cen(i_CEN), .i_upd(w_vupd),
    .i_set(r_vcnt == i_REG.i_VS_BEG), .i_clr(r_vcnt == i_REG.i_VS_END), .o_nx(w_vs_nx));
  ika9958_st_prog_srl #(.RST_VAL(1'b1)) u_vb (
    .i_clk(i_phiA), .i_rst(i_RST), .i_cen(i_CEN), .i_upd(w_vupd),
    .i_set(r_vcnt == i_REG.i_VB_BEG), .i_clr(r_vcnt == i_REG.i_VB_END), .o_nx(w_vb_nx));

  assign w_hpos = r_hcnt + {{(HW-ADJW){i_REG.i_HADJ[ADJW-1]}}, i_REG.i_HADJ};
  assign w_vpos = r_vcnt + {{(VW-ADJW){i_REG.i_VADJ[ADJW-1]}}, i_REG.i_VADJ};

  // Composite outputs are built from the flags' next values so they line
  // up with the flags themselves and keep their own reset levels.
  always_ff @(posedge i_phiA) begin
    if (i_RST) begin
      r_hcnt_o  <= '0;
      r_vcnt_o  <= '0;
      r_hpos    <= '0;
      r_vpos    <= '0;
      r_field_o <= FIELD_PRI;
      r_hsync_n <= 1'b1;
      r_vsync_n <= 1'b1;
      r_csync_n <= 1'b1;
      r_blank_n <= 1'b1;
      r_de      <= 1'b0;
      r_tick    <= 1'b0;
    end else if (i_CEN) begin
      r_hcnt_o  <= r_hcnt;
      r_vcnt_o  <= r_vcnt;
      r_hpos    <= w_hpos;
      r_vpos    <= w_vpos;
      r_field_o <= r_field;
      r_hsync_n <= ~w_hs_nx;
      r_vsync_n <= ~w_vs_nx;
      r_csync_n <= w_vs_nx ? w_hs_nx : ~w_hs_nx;
      r_blank_n <= ~(w_hb_nx | w_vb_nx);
      r_de      <= ~w_hb_nx & ~w_vb_nx;
      r_tick    <= (w_vpos == i_REG.i_LINE_CMP) && (r_hcnt == '0);
    end
  end

  assign o_HCNT      = r_hcnt_o;
  assign o_VCNT      = r_vcnt_o;
  assign o_HPOS      = r_hpos;
  assign o_VPOS      = r_vpos;
  assign o_FIELD     = r_field_o;
  assign o_HSYNC_n   = r_hsync_n;
  assign o_VSYNC_n   = r_vsync_n;
  assign o_CSYNC_n   = r_csync_n;
  assign o_BLANK_n   = r_blank_n;
  assign o_DE        = r_de;
  assign o_LINE_TICK = r_tick;
endmodule

// File: tb/tb_ika9958_st_prog.sv
// tb_ika9958_st_prog: directed self-checking bench for ika9958_st_prog.
// Observed outputs trail the internal counters by one CEN, so every
// expectation below is written in terms of the observed o_HCNT/o_VCNT.
// Genlock expectations follow IKA9958_ST_PROG_GENLOCK_EN.
module tb_ika9958_st_prog;
  import ika9958_st_pkg::*;

  localparam int HW = 9, VW = 9, ADJW = 4;
  localparam int LIM = 12000;

  logic clk = 1'b0;
  logic rst, cen, hrst_n, vrst_n;
  logic [HW-1:0] hcnt, hpos;
  logic [VW-1:0] vcnt, vpos;
  logic hs_n, vs_n, cs_n, blank_n, de, field, tick;
  int n_checks = 0;
  int n_fail   = 0;

  ika9958_st_prog_if #(.HW(HW), .VW(VW), .ADJW(ADJW)) regs();

  ika9958_st_prog #(.HW(HW), .VW(VW), .ADJW(ADJW)) dut (
    .i_phiA(clk), .i_RST(rst), .i_CEN(cen), .i_REG(regs),
    .i_HRST_n(hrst_n), .i_VRST_n(vrst_n),
    .o_HCNT(hcnt), .o_VCNT(vcnt), .o_HPOS(hpos), .o_VPOS(vpos),
    .o_HSYNC_n(hs_n), .o_VSYNC_n(vs_n), .o_CSYNC_n(cs_n),
    .o_BLANK_n(blank_n), .o_DE(de), .o_FIELD(field), .o_LINE_TICK(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v; int h;
    int hs_n; int vs_n; int cs_n; int blank_n; int de;
  } flag_vec_t;
  flag_vec_t tbl[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic seek(input int v, input int h, input int f, input string nm);
    int n = 0;
    while (!(int'(vcnt) == v && int'(hcnt) == h && (f < 0 || int'(field) == f)) && n < LIM) begin
      step();
      n++;
    end
    chk({"reach ", nm}, int'(n < LIM), 1);
  endtask

  task automatic cfg_default();
    regs.i_HTOTAL = ST_HTOTAL_NTSC;
    regs.i_HS_BEG = 9'd300; regs.i_HS_END = 9'd325;
    regs.i_HB_BEG = 9'd280; regs.i_HB_END = 9'd10;
    regs.i_VTOTAL = 9'd19;
    regs.i_VS_BEG = 9'd15;  regs.i_VS_END = 9'd17;
    regs.i_VB_BEG = 9'd14;  regs.i_VB_END = 9'd2;
    regs.i_IL = 1'b0;
    regs.i_HADJ = '0; regs.i_VADJ = '0;
    regs.i_LINE_CMP = 9'd300;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cen = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, lines, seen;
    hrst_n = 1'b1;
    vrst_n = 1'b1;
    cfg_default();

    // {v, h, hsync_n, vsync_n, csync_n, blank_n, de} at observed (o_VCNT, o_HCNT)
    tbl[0] = '{1,   5,   1, 1, 1, 0, 0};
    tbl[1] = '{3,   50,  1, 1, 1, 1, 1};
    tbl[2] = '{3,   300, 0, 1, 0, 0, 0};
    tbl[3] = '{3,   325, 1, 1, 1, 0, 0};
    tbl[4] = '{15,  299, 1, 1, 1, 0, 0};
    tbl[5] = '{15,  300, 0, 0, 1, 0, 0};
    tbl[6] = '{15,  330, 1, 0, 0, 0, 0};
    tbl[7] = '{17,  300, 0, 1, 0, 0, 0};
    tbl[8] = '{0,   9,   1, 1, 1, 0, 0};

    // Reset
    do_reset();
    chk("rst hcnt", hcnt, 0);
    chk("rst vcnt", vcnt, 0);
    chk("rst hsync_n", hs_n, 1);
    chk("rst vsync_n", vs_n, 1);
    chk("rst csync_n", cs_n, 1);
    chk("rst blank_n", blank_n, 1);
    chk("rst de", de, 0);
    chk("rst field", field, 0);
    chk("rst tick", tick, 0);

    // Sync/blank windows, non-interlaced
    for (int i = 0; i < 9; i++) begin
      seek(tbl[i].v, tbl[i].h, -1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d hsync_n", i), hs_n, tbl[i].hs_n);
      chk($sformatf("vec%0d vsync_n", i), vs_n, tbl[i].vs_n);
      chk($sformatf("vec%0d csync_n", i), cs_n, tbl[i].cs_n);
      chk($sformatf("vec%0d blank_n", i), blank_n, tbl[i].blank_n);
      chk($sformatf("vec%0d de", i), de, tbl[i].de);
    end

    // Line length and line increment
    seek(4, 0, -1, "line4");
    cnt = 0;
    do begin step(); cnt++; end while (hcnt != 0 && cnt < 1000);
    chk("line length", cnt, 342);
    chk("line incr vcnt", vcnt, 5);

    // Frame length (VTOTAL=19 -> 20 lines), field stays primary
    seek(0, 0, -1, "frame start");
    lines = 0; seen = 0; cnt = 0;
    do begin
      step(); cnt++;
      if (field) seen = 1;
      if (hcnt == 0) lines++;
    end while (!(hcnt == 0 && vcnt == 0) && cnt < LIM);
    chk("frame lines", lines, 20);
    chk("noIL field", seen, 0);

    // HSYNC low width over one line
    seek(3, 0, -1, "hs width line");
    cnt = 0;
    for (int i = 0; i < 342; i++) begin step(); if (!hs_n) cnt++; end
    chk("hsync width", cnt, 25);

    // CEN low holds everything
    cen = 1'b0;
    begin
      int h0, v0;
      h0 = hcnt; v0 = vcnt;
      repeat (6) step();
      chk("cen hold hcnt", hcnt, h0);
      chk("cen hold vcnt", vcnt, v0);
      cen = 1'b1;
      step();
      chk("cen resume hcnt", hcnt, (h0 + 1) % 342);
    end

    // Interlace: field 1 has 19 lines, field 0 has 20
    regs.i_IL = 1'b1;
    do_reset();
    seek(0, 0, 1, "field1 start");
    lines = 1; cnt = 0;
    do begin
      step(); cnt++;
      if (hcnt == 0 && field == 1) lines++;
    end while (!(hcnt == 0 && field == 0) && cnt < LIM);
    chk("field1 lines", lines, 19);
    chk("field toggles to 0", field, 0);
    lines = 1; cnt = 0;
    do begin
      step(); cnt++;
      if (hcnt == 0 && field == 0) lines++;
    end while (!(hcnt == 0 && field == 1) && cnt < LIM);
    chk("field0 lines", lines, 20);
    chk("field toggles to 1", field, 1);
    seek(15, 170, 1, "field1 vsync");
    chk("f1 vsync before half", vs_n, 1);
    step();
    chk("f1 vsync hcnt", hcnt, 171);
    chk("f1 vsync at half", vs_n, 0);

    // Position adjust and line tick
    cfg_default();
    regs.i_HADJ = 4'hF;
    regs.i_VADJ = 4'h2;
    regs.i_LINE_CMP = 9'd10;
    do_reset();
    seek(7, 0, -1, "adj v7");
    chk("v7 tick", tick, 0);
    chk("v7 vpos", vpos, 9);
    chk("v7 hpos", hpos, 511);
    seek(8, 0, -1, "adj v8");
    chk("v8 tick", tick, 1);
    chk("v8 hpos", hpos, 511);
    chk("v8 vpos", vpos, 10);
    step();
    chk("v8 tick width", tick, 0);
    chk("v8 h1 hpos", hpos, 0);
    cnt = 0;
    for (int i = 0; i < 20 * 342; i++) begin step(); if (tick) cnt++; end
    chk("ticks per frame", cnt, 1);

    // HB_BEG == HB_END: set wins, blank latches on
    seek(5, 50, -1, "hb eq");
    regs.i_HB_BEG = 9'd100;
    regs.i_HB_END = 9'd100;
    seek(5, 99, -1, "hb eq 99");
    chk("hb eq before", blank_n, 1);
    step();
    chk("hb eq set", blank_n, 0);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin step(); if (blank_n) cnt++; end
    chk("hb eq stays", cnt, 0);
    regs.i_HB_BEG = 9'd280;
    regs.i_HB_END = 9'd10;

    // HTOTAL reprogrammed below the current count
    seek(9, 299, -1, "htotal drop");
    regs.i_HTOTAL = 9'd200;
    step();
    chk("htotal drop pipe", hcnt, 300);
    step();
    chk("htotal drop wrap", hcnt, 0);
    regs.i_HTOTAL = ST_HTOTAL_NTSC;

    // Genlock V reset at line 100
    cfg_default();
    regs.i_HTOTAL = 9'd41;
    regs.i_HS_BEG = 9'd30; regs.i_HS_END = 9'd35;
    regs.i_HB_BEG = 9'd36; regs.i_HB_END = 9'd5;
    regs.i_VTOTAL = ST_VTOTAL_NTSC;
    do_reset();
    seek(100, 5, -1, "genlock v100");
    vrst_n = 1'b0;
`ifdef IKA9958_ST_PROG_GENLOCK_EN
    seen = 0;
    for (int i = 0; i < 4 && seen == 0; i++) begin
      step();
      if (vcnt == 0 && hcnt == 0 && field == 0) seen = 1;
    end
    chk("genlock vrst", seen, 1);
`else
    repeat (6) step();
    chk("genlock off vcnt", vcnt, 100);
    chk("genlock off hcnt", hcnt, 11);
`endif
    vrst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
